// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and width helpers for the SPI transfer controller.
package spi_pkg;
   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   localparam int HDR_LEN = ADDR_W_DEF + 1;
   localparam int CNT_W = $clog2((HDR_LEN > DATA_W_DEF ? HDR_LEN : DATA_W_DEF) + 1);
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      HDR       = 4'd1,
      DECODE    = 4'd2,
      RD_FETCH  = 4'd3,
      RD_LOAD   = 4'd4,
      RD_SHIFT  = 4'd5,
      RD_INC    = 4'd6,
      WR_SHIFT  = 4'd7,
      WR_COMMIT = 4'd8,
      DONE      = 4'd9
   } state_e;
   function automatic int calc_cnt_w(input int aw, input int dw);
      return $clog2(((aw + 1) > dw ? aw + 1 : dw) + 1);
   endfunction
endpackage

// File: rtl/spi_xfer_fsm_if.sv
// spi_xfer_fsm_if: conditioned SPI inputs and datapath strobes of the transfer controller.
interface spi_xfer_fsm_if;
   logic cs_n, sclk_rise, sclk_fall, rw_bit;
   logic addr_we, addr_inc, sr_load, dm_we, miso_oe, busy, frame_err;
   modport master (
      output cs_n, sclk_rise, sclk_fall, rw_bit,
      input  addr_we, addr_inc, sr_load, dm_we, miso_oe, busy, frame_err
   );
   modport slave (
      input  cs_n, sclk_rise, sclk_fall, rw_bit,
      output addr_we, addr_inc, sr_load, dm_we, miso_oe, busy, frame_err
   );
endinterface

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: bit counter with sync clear and a flag for the increment that reaches term.
module spi_bit_counter import spi_pkg::*; #(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         last
);
   always_ff @(posedge clk)
      cnt <= (reset || clr) ? '0 : en ? cnt + 1'b1 : cnt;
   assign last = en && (cnt + 1'b1 == term);
endmodule

// File: rtl/spi_xfer_fsm.sv
// spi_xfer_fsm: SPI memory slave control FSM with configurable widths, optional burst and frame-error flag.
module spi_xfer_fsm import spi_pkg::*; #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter bit BURST_EN = 1'b1
) (
   input logic          clk,
   input logic          reset,
   spi_xfer_fsm_if.slave bus
);
   localparam int HDR_N = ADDR_W + 1;
   localparam int CW = calc_cnt_w(ADDR_W, DATA_W);
   state_e state, state_nx;
   logic [CW-1:0] bit_cnt, term;
   logic cnt_en, cnt_clr, cnt_last, err_nx, frame_err_q;
   // Reads shift out on falls; a fall coinciding with a rise is dropped.
   assign cnt_en = (state == HDR || state == WR_SHIFT) ? bus.sclk_rise :
                   (state == RD_SHIFT) ? bus.sclk_fall && !bus.sclk_rise : 1'b0;
   assign term = (state == HDR) ? CW'(HDR_N) : CW'(DATA_W);
   assign cnt_clr = bus.cs_n || state == IDLE || cnt_last;
   assign err_nx = bus.cs_n && bit_cnt != '0 && state inside {HDR, RD_SHIFT, WR_SHIFT};
   spi_bit_counter #(.W(CW)) u_cnt (
      .clk(clk), .reset(reset), .clr(cnt_clr), .en(cnt_en),
      .term(term), .cnt(bit_cnt), .last(cnt_last)
   );
   always_ff @(posedge clk)
      if (reset) begin
         state       <= IDLE;
         frame_err_q <= 1'b0;
      end else begin
         state       <= state_nx;
         frame_err_q <= err_nx;
      end
   always_comb begin
      state_nx = state;
      if (bus.cs_n) state_nx = IDLE;
      else
         case (state)
            IDLE:      state_nx = HDR;
            HDR:       state_nx = cnt_last ? DECODE : HDR;
            DECODE:    state_nx = bus.rw_bit ? RD_FETCH : WR_SHIFT;
            RD_FETCH:  state_nx = RD_LOAD;
            RD_LOAD:   state_nx = RD_SHIFT;
            RD_SHIFT:  state_nx = !cnt_last ? RD_SHIFT : BURST_EN ? RD_INC : DONE;
            RD_INC:    state_nx = RD_FETCH;
            WR_SHIFT:  state_nx = cnt_last ? WR_COMMIT : WR_SHIFT;
            WR_COMMIT: state_nx = BURST_EN ? WR_SHIFT : DONE;
            DONE:      state_nx = DONE;
            default:   state_nx = IDLE;
         endcase
   end
   // Spare encodings fall outside every list below, so they look like IDLE.
   always_comb begin
      bus.busy      = state inside {HDR, DECODE, RD_FETCH, RD_LOAD, RD_SHIFT, RD_INC, WR_SHIFT, WR_COMMIT, DONE};
      bus.addr_we   = state == DECODE;
      bus.addr_inc  = state == RD_INC || (BURST_EN && state == WR_COMMIT);
      bus.sr_load   = state == RD_LOAD;
      bus.dm_we     = state == WR_COMMIT;
      bus.miso_oe   = state == RD_SHIFT;
      bus.frame_err = frame_err_q;
   end
endmodule

// File: tb/tb_spi_xfer_fsm.sv
// tb_spi_xfer_fsm: single-word and burst controllers driven in lockstep against a strobe-schedule model.
module tb_spi_xfer_fsm;
   localparam int AW = 7, DW = 8, HL = AW + 1;
   localparam int P_IDLE = 0, P_HDR = 1, P_RD = 2, P_WR = 3, P_DONE = 4;
   localparam logic [6:0] S_B = 7'b1000000, S_ERR = 7'b0100000, S_AWE = 7'b0010000,
                          S_INC = 7'b0001000, S_LD = 7'b0000100, S_WE = 7'b0000010, S_OE = 7'b0000001;
   typedef struct {
      logic c, r, f;
      int gap;
      logic [6:0] es, eb;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1;
   logic cs_n = 1'b1, rise = 1'b0, fall = 1'b0, rw = 1'b0;
   logic [6:0] o_s, o_b;
   int total = 0, passed = 0;
   int n_ld, n_inc, n_co, n_we_s;
   int ph[2], nb[2], nph[2], sn[2];
   logic [6:0] sq[2][3];
   logic ferr[2];
   vec_t tv[$];
   spi_xfer_fsm_if if_s();
   spi_xfer_fsm_if if_b();
   assign if_s.cs_n = cs_n;
   assign if_s.sclk_rise = rise;
   assign if_s.sclk_fall = fall;
   assign if_s.rw_bit = rw;
   assign if_b.cs_n = cs_n;
   assign if_b.sclk_rise = rise;
   assign if_b.sclk_fall = fall;
   assign if_b.rw_bit = rw;
   assign o_s = {if_s.busy, if_s.frame_err, if_s.addr_we, if_s.addr_inc, if_s.sr_load, if_s.dm_we, if_s.miso_oe};
   assign o_b = {if_b.busy, if_b.frame_err, if_b.addr_we, if_b.addr_inc, if_b.sr_load, if_b.dm_we, if_b.miso_oe};
   spi_xfer_fsm #(.ADDR_W(AW), .DATA_W(DW), .BURST_EN(1'b0)) u_s (.clk(clk), .reset(reset), .bus(if_s.slave));
   spi_xfer_fsm #(.ADDR_W(AW), .DATA_W(DW), .BURST_EN(1'b1)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
   endtask
   task automatic chk_n(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask
   // Fixed-latency strobe sequences are queued; edges are ignored while one is pending.
   task automatic sched(input int b, input logic [6:0] a0, a1, a2, input int n, input int next);
      sq[b][0] = a0; sq[b][1] = a1; sq[b][2] = a2; sn[b] = n; nph[b] = next;
   endtask
   task automatic model_step(input int b, input bit burst);
      ferr[b] = 1'b0;
      if (reset) begin
         ph[b] = P_IDLE; sn[b] = 0; nb[b] = 0;
      end else if (cs_n) begin
         ferr[b] = sn[b] == 0 && ph[b] inside {P_HDR, P_RD, P_WR} && nb[b] != 0;
         ph[b] = P_IDLE; sn[b] = 0; nb[b] = 0;
      end else if (sn[b] > 0) begin
         sq[b][0] = sq[b][1]; sq[b][1] = sq[b][2]; sn[b]--;
         if (sn[b] == 0) ph[b] = nph[b];
      end else if (ph[b] == P_IDLE) begin
         ph[b] = P_HDR; nb[b] = 0;
      end else if (ph[b] == P_HDR && rise) begin
         nb[b]++;
         if (nb[b] == HL) begin
            nb[b] = 0;
            if (rw) sched(b, S_AWE, 7'b0, S_LD, 3, P_RD);
            else sched(b, S_AWE, 7'b0, 7'b0, 1, P_WR);
         end
      end else if (ph[b] == P_RD && fall && !rise) begin
         nb[b]++;
         if (nb[b] == DW) begin
            nb[b] = 0;
            if (burst) sched(b, S_INC, 7'b0, S_LD, 3, P_RD);
            else ph[b] = P_DONE;
         end
      end else if (ph[b] == P_WR && rise) begin
         nb[b]++;
         if (nb[b] == DW) begin
            nb[b] = 0;
            sched(b, burst ? (S_WE | S_INC) : S_WE, 7'b0, 7'b0, 1, burst ? P_WR : P_DONE);
         end
      end
   endtask
   function automatic logic [6:0] expv(input int b);
      logic [6:0] e;
      e = sn[b] > 0 ? (S_B | sq[b][0]) : ph[b] == P_IDLE ? 7'b0 : ph[b] == P_RD ? (S_B | S_OE) : S_B;
      return ferr[b] ? (e | S_ERR) : e;
   endfunction
   task automatic cyc(input logic c, input logic r, input logic f);
      cs_n = c; rise = r; fall = f;
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      @(posedge clk);
      #1;
      chk("single", o_s, expv(0));
      chk("burst", o_b, expv(1));
      n_ld += int'(if_b.sr_load);
      n_inc += int'(if_b.addr_inc);
      n_co += int'(if_b.dm_we && if_b.addr_inc);
      n_we_s += int'(if_s.dm_we);
      rise = 1'b0; fall = 1'b0;
   endtask
   task automatic edge_(input logic r, input logic f, input int gap);
      cyc(1'b0, r, f);
      repeat (gap) cyc(1'b0, 1'b0, 1'b0);
   endtask
   task automatic start_frame(input logic rd);
      cyc(1'b1, 1'b0, 1'b0);
      rw = rd;
      cyc(1'b0, 1'b0, 1'b0);
      n_ld = 0; n_inc = 0; n_co = 0; n_we_s = 0;
   endtask
   function automatic vec_t mk(input logic c, r, f, input int gap, input logic [6:0] es, eb);
      vec_t v;
      v.c = c; v.r = r; v.f = f; v.gap = gap; v.es = es; v.eb = eb;
      return v;
   endfunction
   initial begin
      tv.push_back(mk(0, 0, 0, 0, S_B, S_B));
      for (int i = 0; i < HL - 1; i++) tv.push_back(mk(0, 1, 0, 4, S_B, S_B));
      tv.push_back(mk(0, 1, 0, 4, S_B | S_AWE, S_B | S_AWE));
      for (int i = 0; i < DW - 1; i++) tv.push_back(mk(0, 1, 0, 4, S_B, S_B));
      tv.push_back(mk(0, 1, 0, 4, S_B | S_WE, S_B | S_WE | S_INC));
      tv.push_back(mk(0, 0, 0, 0, S_B, S_B));
      tv.push_back(mk(1, 0, 0, 0, 7'b0, 7'b0));
      n_ld = 0; n_inc = 0; n_co = 0; n_we_s = 0;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("reset_s", o_s, 7'b0);
      chk("reset_b", o_b, 7'b0);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      rw = 1'b0;
      foreach (tv[i]) begin
         cyc(tv[i].c, tv[i].r, tv[i].f);
         chk($sformatf("vec%0d_s", i), o_s, tv[i].es);
         chk($sformatf("vec%0d_b", i), o_b, tv[i].eb);
         repeat (tv[i].gap) cyc(tv[i].c, 1'b0, 1'b0);
      end
      // single read: addr_we, idle fetch, sr_load, then 8 falls under miso_oe
      start_frame(1'b1);
      for (int i = 0; i < HL - 1; i++) edge_(1'b1, 1'b0, 4);
      edge_(1'b1, 1'b0, 0);
      chk("rd_decode", o_s, S_B | S_AWE);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rd_fetch", o_s, S_B);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rd_load", o_s, S_B | S_LD);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rd_shift", o_s, S_B | S_OE);
      for (int i = 0; i < DW - 1; i++) edge_(1'b0, 1'b1, 4);
      chk("rd_oe_held", o_s, S_B | S_OE);
      edge_(1'b0, 1'b1, 2);
      chk("rd_done", o_s, S_B);
      cyc(1'b1, 1'b0, 1'b0);
      chk("rd_deselect", o_s, 7'b0);
      // burst read of three words, deselected right after the last fall
      start_frame(1'b1);
      for (int i = 0; i < HL; i++) edge_(1'b1, 1'b0, 4);
      for (int i = 0; i < 3 * DW - 1; i++) edge_(1'b0, 1'b1, 4);
      edge_(1'b0, 1'b1, 0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("brd_end", o_b, 7'b0);
      chk_n("brd_sr_load", n_ld, 3);
      chk_n("brd_addr_inc", n_inc, 3);
      // burst write of two words
      start_frame(1'b0);
      for (int i = 0; i < HL + 2 * DW; i++) edge_(1'b1, 1'b0, 4);
      chk_n("bwr_we_inc", n_co, 2);
      chk_n("bwr_single_we", n_we_s, 1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("bwr_end", o_b, 7'b0);
      // truncated write after 5 data rises
      start_frame(1'b0);
      for (int i = 0; i < HL + 5; i++) edge_(1'b1, 1'b0, 4);
      cyc(1'b1, 1'b0, 1'b0);
      chk("trunc_err_s", o_s, S_ERR);
      chk("trunc_err_b", o_b, S_ERR);
      cyc(1'b1, 1'b0, 1'b0);
      chk("trunc_idle", o_s, 7'b0);
      chk_n("trunc_no_we", n_we_s, 0);
      // reset in the middle of a read shift, then a fresh header
      start_frame(1'b1);
      for (int i = 0; i < HL; i++) edge_(1'b1, 1'b0, 4);
      for (int i = 0; i < 3; i++) edge_(1'b0, 1'b1, 4);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk("rst_mid_s", o_s, 7'b0);
      chk("rst_mid_b", o_b, 7'b0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      chk("rst_rehdr", o_s, S_B);
      for (int i = 0; i < HL - 1; i++) edge_(1'b1, 1'b0, 4);
      edge_(1'b1, 1'b0, 0);
      chk("rst_hdr_full", o_s, S_B | S_AWE);
      cyc(1'b1, 1'b0, 1'b0);
      // random traffic, including coincident edges and occasional resets
      for (int k = 0; k < 400; k++) begin
         int a, kd;
         a = $urandom_range(0, 99);
         kd = $urandom_range(0, 9);
         if (a < 4) begin
            cyc(1'b1, 1'b0, 1'b0);
            rw = 1'($urandom_range(0, 1));
            cyc(1'b1, 1'b0, 1'b0);
         end else if (a < 6) begin
            reset = 1'b1;
            cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            reset = 1'b0;
         end else edge_(kd < 5 || kd == 9, kd >= 5, $urandom_range(3, 6));
      end
      cyc(1'b1, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
